// File: rtl/count_up_stopwatch_pkg.sv
// Shared types and constants for the count-up stopwatch slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FULL  = 2'd3
  } sw_state_t;

  localparam int              SEC_W   = 8;
  localparam logic [SEC_W-1:0] SEC_MAX = 8'd59;

endpackage

// File: rtl/count_up_stopwatch_if.sv
// Button and display bundle shared by the stopwatch and the kitchen timer display path.
interface count_up_stopwatch_if #(
  parameter int MIN_W = 2
);
  logic                            start;
  logic                            stop;
  logic                            clear;
  logic                            lap;
  logic                            running;
  logic [MIN_W-1:0]                minute;
  logic [stopwatch_pkg::SEC_W-1:0] second;
  logic                            full;
  logic [MIN_W-1:0]                lap_minute;
  logic [stopwatch_pkg::SEC_W-1:0] lap_second;
  logic                            lap_valid;

  modport master (
    output start, stop, clear, lap,
    input  running, minute, second, full, lap_minute, lap_second, lap_valid
  );

  modport slave (
    input  start, stop, clear, lap,
    output running, minute, second, full, lap_minute, lap_second, lap_valid
  );
endinterface

// File: rtl/count_up_stopwatch_sec_tick_gen.sv
// Seconds prescaler: counts enabled cycles and emits a one-cycle tick on wrap.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int               CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Combinational so the owning counter advances on the same edge as the wrap.
  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/count_up_stopwatch.sv
// Count-up stopwatch with pause/resume, clear, saturation flag and optional lap capture.
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
//
// state | meaning
// IDLE  | stopped at 0:00, waiting for start
// RUN   | counting, prescaler enabled
// PAUSE | frozen, fractional second retained
// FULL  | saturated at MAX_MIN:59 until clear
module count_up_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int MIN_W         = 2,
  parameter int MAX_MIN       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  count_up_stopwatch_if.slave  bus
);
  localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

  sw_state_t        state_q, state_d;
  logic [MIN_W-1:0] minute_q, minute_d, minute_inc;
  logic [SEC_W-1:0] second_q, second_d, second_inc;
  logic             running_q, full_q;
  logic             tick;

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == RUN),
    .clear  (bus.clear),
    .tick   (tick)
  );

  always_comb begin
    second_inc = second_q + SEC_W'(1);
    minute_inc = minute_q;
    if (second_q == SEC_MAX) begin
      second_inc = '0;
      minute_inc = minute_q + MIN_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    minute_d = minute_q;
    second_d = second_q;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (bus.start && !bus.stop) state_d = RUN;
      end
      RUN: begin
        if (tick) begin
          minute_d = minute_inc;
          second_d = second_inc;
        end
        // Reaching full time takes precedence over a coincident stop.
        if (tick && minute_inc == MAX_MIN_V && second_inc == SEC_MAX) state_d = FULL;
        else if (bus.stop)                                             state_d = PAUSE;
      end
      FULL: state_d = FULL;
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d  = IDLE;
      minute_d = '0;
      second_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      minute_q  <= '0;
      second_q  <= '0;
      running_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      minute_q  <= minute_d;
      second_q  <= second_d;
      running_q <= (state_d == RUN);
      full_q    <= (state_d == FULL);
    end
  end

  assign bus.running = running_q;
  assign bus.minute  = minute_q;
  assign bus.second  = second_q;
  assign bus.full    = full_q;

`ifdef STOPWATCH_LAP_EN
  logic [MIN_W-1:0] lap_minute_q;
  logic [SEC_W-1:0] lap_second_q;
  logic             lap_valid_q;

  // Captures the pre-edge time, so a lap on a tick cycle records the old second.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      lap_minute_q <= '0;
      lap_second_q <= '0;
      lap_valid_q  <= 1'b0;
    end else begin
      lap_valid_q <= 1'b0;
      if (bus.lap && (state_q == RUN || state_q == PAUSE)) begin
        lap_minute_q <= minute_q;
        lap_second_q <= second_q;
        lap_valid_q  <= 1'b1;
      end
    end
  end

  assign bus.lap_minute = lap_minute_q;
  assign bus.lap_second = lap_second_q;
  assign bus.lap_valid  = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap     = bus.lap;
  assign bus.lap_minute = '0;
  assign bus.lap_second = '0;
  assign bus.lap_valid  = 1'b0;
`endif
endmodule
